// File: rtl/mvau_weight_stream.sv
// mvau_weight_stream: sweeps the weight memory num_passes times and streams each word over AXI-Stream
// A read is issued only when the 2-entry buffer can absorb it, so a stalled consumer never loses a word.
module mvau_weight_stream #(
    parameter int SIMD         = 2,
    parameter int TW           = 1,
    parameter int WMEM_DEPTH   = 4,
    parameter int WMEM_ADDR_BW = 4
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    start,
    input  logic [15:0]             num_passes,
    output logic                    busy,
    output logic                    done,
    output logic [WMEM_ADDR_BW-1:0] wmem_addr,
    input  logic [SIMD*TW-1:0]      wmem_in,
    output logic [SIMD*TW-1:0]      m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast
);
    localparam int W = SIMD * TW;
    localparam logic [WMEM_ADDR_BW-1:0] LAST_ADDR = WMEM_ADDR_BW'(WMEM_DEPTH - 1);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t                  r_state;
    logic [WMEM_ADDR_BW-1:0] r_addr;
    logic [15:0]             r_pass, r_num;
    logic                    r_inflight, r_inflight_last, r_busy, r_done;
    logic [W-1:0]            r_data [2];
    logic [1:0]              r_last, r_occ;
    logic                    w_pop, w_accept, w_issue, w_wrap, w_final, w_empty;
    logic [1:0]              w_occ_p;
    // Occupancy is taken after this cycle's pop so a full-rate stream has no bubbles.
    // The address is always 0 in IDLE, so the start cycle itself issues the read of word 0.
    always_comb begin
        w_pop    = m_axis_tvalid && m_axis_tready;
        w_occ_p  = r_occ - {1'b0, w_pop};
        w_accept = r_state == IDLE && start && num_passes != 16'd0;
        w_issue  = w_accept || (r_state == RUN && (w_occ_p + {1'b0, r_inflight}) < 2'd2);
        w_wrap   = r_addr == LAST_ADDR;
        w_final  = r_state == RUN && w_issue && w_wrap && r_pass == r_num - 16'd1;
        w_empty  = w_occ_p == 2'd0 && !r_inflight;
    end
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state         <= IDLE;
            r_addr          <= '0;
            r_pass          <= '0;
            r_num           <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_data[0]       <= '0;
            r_data[1]       <= '0;
            r_last          <= '0;
            r_occ           <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_done <= num_passes == 16'd0;
                    if (num_passes != 16'd0) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                        r_num   <= num_passes;
                        r_pass  <= '0;
                    end
                end
                RUN: if (w_final) r_state <= DRAIN;
                DRAIN: if (w_empty) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_last <= w_wrap;
                r_addr          <= w_wrap ? '0 : r_addr + 1'b1;
                if (w_wrap) r_pass <= r_pass + 16'd1;
            end
            if (w_pop) begin
                r_data[0] <= r_data[1];
                r_last[0] <= r_last[1];
            end
            if (r_inflight) begin
                r_data[w_occ_p[0]] <= wmem_in;
                r_last[w_occ_p[0]] <= r_inflight_last;
            end
            r_occ <= w_occ_p + {1'b0, r_inflight};
        end
    end
    assign busy          = r_busy;
    assign done          = r_done;
    assign wmem_addr     = r_addr;
    assign m_axis_tdata  = r_data[0];
    assign m_axis_tvalid = r_occ != 2'd0;
    assign m_axis_tlast  = r_last[0] && m_axis_tvalid;
endmodule

// File: tb/tb_mvau_weight_stream.sv
// tb_mvau_weight_stream: table-driven jobs against a word-indexed model of the weight memory
module tb_mvau_weight_stream;
    logic        aclk = 0, areset = 1, start = 0, m_axis_tready = 1;
    logic [15:0] num_passes = 0;
    logic        busy, done, m_axis_tvalid, m_axis_tlast;
    logic [3:0]  wmem_addr;
    logic [7:0]  wmem_in, m_axis_tdata;
    logic [7:0]  mem [16];
    int tests = 0, fails = 0, cyc = 0, tr_mode = 0, s_cyc = 0;
    logic [7:0] q_data[$];
    logic       q_last[$];
    int first_v, last_cyc, done_cyc, done_cnt, done_busy_err, stall_err, busy_seen;
    logic prev_stall = 0, prev_last = 0;
    logic [7:0] prev_data = 0;

    mvau_weight_stream #(.SIMD(4), .TW(2), .WMEM_DEPTH(4), .WMEM_ADDR_BW(4)) dut (
        .aclk(aclk), .areset(areset), .start(start), .num_passes(num_passes),
        .busy(busy), .done(done), .wmem_addr(wmem_addr), .wmem_in(wmem_in),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast));

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;
    always @(posedge aclk) wmem_in <= mem[wmem_addr];

    always @(negedge aclk) begin
        if (!areset) begin
            if (prev_stall && (!m_axis_tvalid || m_axis_tdata != prev_data || m_axis_tlast != prev_last))
                stall_err++;
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            if (m_axis_tvalid && m_axis_tready) begin
                q_data.push_back(m_axis_tdata);
                q_last.push_back(m_axis_tlast);
                last_cyc = cyc;
            end
            if (m_axis_tvalid && first_v < 0) first_v = cyc;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (busy) done_busy_err++;
            end
            if (busy) busy_seen = 1;
        end else prev_stall = 0;
    end

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
        m_axis_tready = tr_mode == 0 ? 1'b1 : tr_mode == 1 ? ~m_axis_tready : 1'($urandom_range(0, 1));
    endtask

    task automatic clear_mon();
        q_data.delete();
        q_last.delete();
        first_v = -1; last_cyc = -1; done_cyc = -1;
        done_cnt = 0; done_busy_err = 0; stall_err = 0; busy_seen = 0;
    endtask

    task automatic run_job(input logic [15:0] np, input int mode, input int sb,
                           input int exp_beats, input int exp_lasts);
        int derr = 0, nl = 0;
        clear_mon();
        tr_mode = mode;
        m_axis_tready = 1'b1;
        num_passes = np;
        start = 1'b1;
        s_cyc = cyc;
        tick();
        start = 1'b0;
        num_passes = 0;
        for (int i = 0; i < 400 && done_cnt == 0; i++) begin
            if (i == sb) begin
                start = 1'b1;
                num_passes = 16'd5;
            end
            tick();
            start = 1'b0;
        end
        if (done_cnt == 0) chk("done_timeout", 0, 1);
        for (int i = 0; i < 4; i++) tick();
        foreach (q_data[k]) begin
            if (q_data[k] != 8'hA0 + 8'(k % 4) || q_last[k] != (k % 4 == 3)) derr++;
            if (q_last[k]) nl++;
        end
        chk("beats", q_data.size(), exp_beats);
        chk("tlast_beats", nl, exp_lasts);
        chk("data_order", derr, 0);
        chk("done_pulses", done_cnt, 1);
        chk("stall_stability", stall_err, 0);
        chk("busy_at_done", done_busy_err, 0);
        chk("busy_seen", busy_seen, int'(np != 0));
        if (np == 0) chk("zero_done_latency", done_cyc - s_cyc, 1);
        else chk("done_after_last", done_cyc - last_cyc, 1);
        if (mode == 0 && np != 0) chk("first_beat_latency", first_v - s_cyc, 2);
    endtask

    typedef struct {
        logic [15:0] np;
        int mode;
        int sb;
        int exp_beats;
        int exp_lasts;
    } vec_t;

    initial begin
        vec_t vecs [7];
        vecs[0] = '{16'd2, 0, -1, 8, 2};
        vecs[1] = '{16'd2, 1, -1, 8, 2};
        vecs[2] = '{16'd2, 2, -1, 8, 2};
        vecs[3] = '{16'd0, 0, -1, 0, 0};
        vecs[4] = '{16'd2, 0,  3, 8, 2};
        vecs[5] = '{16'd1, 0, -1, 4, 1};
        vecs[6] = '{16'd3, 1, -1, 12, 3};
        for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(i);
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_addr", wmem_addr, 0);
        areset = 0;
        foreach (vecs[i]) run_job(vecs[i].np, vecs[i].mode, vecs[i].sb, vecs[i].exp_beats, vecs[i].exp_lasts);
        clear_mon();
        tr_mode = 0;
        num_passes = 16'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 50 && q_data.size() < 3; i++) tick();
        chk("pre_reset_beats", int'(q_data.size() >= 3), 1);
        areset = 1'b1;
        tick();
        chk("midrst_tvalid", m_axis_tvalid, 0);
        chk("midrst_done", done, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_addr", wmem_addr, 0);
        tick();
        chk("midrst_done2", done, 0);
        chk("midrst_no_done", done_cnt, 0);
        areset = 1'b0;
        run_job(16'd1, 0, -1, 4, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
